// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, default sizes and address-width helper for regfile_mp
package regfile_pkg;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write/read port bundle of the multi-port register file
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = addr_w(DEF_DEPTH),
  parameter int NREAD = 2
);
  logic [1:0]                 we;
  logic [1:0][AW-1:0]         wa;
  logic [1:0][WIDTH-1:0]      wd;
  logic [NREAD-1:0][AW-1:0]   ra;
  logic [NREAD-1:0][WIDTH-1:0] rd;
  logic                       ready;
  logic                       wcoll;
  modport master (output we, wa, wd, ra, input rd, ready, wcoll);
  modport slave  (input we, wa, wd, ra, output rd, ready, wcoll);
endinterface

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sequencer that zeroes every entry before reporting ready
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_ready
);
  state_t        r_state;
  logic [AW-1:0] r_clr_ptr;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_ptr <= r_clr_ptr + AW'(1);
      if (r_clr_ptr == AW'(DEPTH - 1)) r_state <= READY;
    end
  end
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_clr_ptr;
  assign o_ready    = (r_state == READY);
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, two prioritised write ports, NREAD bypassed read ports
module regfile_mp import regfile_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         CLK,
  input logic         RST,
  regfile_mp_if.slave bus
);
  localparam int AW = addr_w(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_rf [DEPTH];
  logic             r_wcoll;
  logic             w_clr_we;
  logic             w_ready;
  logic [AW-1:0]    w_clr_addr;
  logic [1:0]       w_commit;
  regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr (
    .i_clk      (CLK),
    .i_rst      (RST),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );
  for (genvar p = 0; p < 2; p++) begin : g_wr
    assign w_commit[p] = w_ready && bus.we[p] && ({1'b0, bus.wa[p]} < LP_DEPTH) &&
                         !(ZERO_REG != 0 && bus.wa[p] == '0);
  end
  // port 1 is assigned last so it wins a same-address collision
  always_ff @(posedge CLK) begin
    if (w_clr_we) r_rf[w_clr_addr] <= '0;
    if (w_commit[0]) r_rf[bus.wa[0]] <= bus.wd[0];
    if (w_commit[1]) r_rf[bus.wa[1]] <= bus.wd[1];
    r_wcoll <= !RST && (&w_commit) && (bus.wa[0] == bus.wa[1]);
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_null;
    logic          w_hit1;
    logic          w_hit0;
    assign w_ra   = bus.ra[i];
    assign w_null = !w_ready || ({1'b0, w_ra} >= LP_DEPTH) || (ZERO_REG != 0 && w_ra == '0);
    assign w_hit1 = BYPASS != 0 && w_commit[1] && bus.wa[1] == w_ra;
    assign w_hit0 = BYPASS != 0 && w_commit[0] && bus.wa[0] == w_ra;
    assign bus.rd[i] = w_null ? '0 : w_hit1 ? bus.wd[1] : w_hit0 ? bus.wd[0] : r_rf[w_ra];
  end
  assign bus.ready = w_ready;
  assign bus.wcoll = r_wcoll;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two configurations driven in lockstep and checked against an array-based model
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       we = '0;
  logic [1:0][4:0]  wa = '0;
  logic [1:0][31:0] wd = '0;
  logic [3:0][4:0]  ra = '0;
  int n_total = 0;
  int n_bad   = 0;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NREAD(4)) if_a ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NREAD(4)) if_b ();
  assign if_a.we = we; assign if_a.wa = wa; assign if_a.wd = wd; assign if_a.ra = ra;
  assign if_b.we = we; assign if_b.wa = wa; assign if_b.wd = wd; assign if_b.ra = ra;

  regfile_mp #(.WIDTH(32), .DEPTH(24), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .CLK(clk), .RST(rst), .bus(if_a.slave));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) u_b (
    .CLK(clk), .RST(rst), .bus(if_b.slave));

  int          dep [2] = '{24, 32};
  bit          zr  [2] = '{1'b1, 1'b0};
  bit          byp [2] = '{1'b1, 1'b0};
  bit          mready [2];
  int          mcnt [2];
  bit          mcoll [2];
  logic [31:0] mrf [2][32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mcommit(int k, int p);
    return mready[k] && we[p] && int'(wa[p]) < dep[k] && !(zr[k] && wa[p] == 0);
  endfunction

  function automatic logic [31:0] mread(int k, int i);
    int a = int'(ra[i]);
    if (!mready[k] || a >= dep[k] || (zr[k] && a == 0)) return 32'h0;
    if (byp[k] && mcommit(k, 1) && int'(wa[1]) == a) return wd[1];
    if (byp[k] && mcommit(k, 0) && int'(wa[0]) == a) return wd[0];
    return mrf[k][a];
  endfunction

  task automatic step();
    bit c [2][2];
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_a%0d", i), if_a.rd[i], mread(0, i));
      chk($sformatf("rd_b%0d", i), if_b.rd[i], mread(1, i));
    end
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) c[k][p] = mcommit(k, p);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mready[k] = 0; mcnt[k] = 0; mcoll[k] = 0;
        for (int a = 0; a < 32; a++) mrf[k][a] = '0;
      end else if (!mready[k]) begin
        mcnt[k]++;
        mcoll[k] = 0;
        if (mcnt[k] == dep[k]) mready[k] = 1;
      end else begin
        mcoll[k] = c[k][0] && c[k][1] && wa[0] == wa[1];
        if (c[k][0]) mrf[k][wa[0]] = wd[0];
        if (c[k][1]) mrf[k][wa[1]] = wd[1];
      end
    end
    #1;
    chk("ready_a", 32'(if_a.ready), 32'(mready[0]));
    chk("ready_b", 32'(if_b.ready), 32'(mready[1]));
    chk("wcoll_a", 32'(if_a.wcoll), 32'(mcoll[0]));
    chk("wcoll_b", 32'(if_b.wcoll), 32'(mcoll[1]));
  endtask

  task automatic drv(input logic [1:0] w, input int a0, input logic [31:0] d0,
                     input int a1, input logic [31:0] d1, input int r0, input int r1);
    we = w; wa[0] = 5'(a0); wd[0] = d0; wa[1] = 5'(a1); wd[1] = d1;
    ra[0] = 5'(r0); ra[1] = 5'(r1); ra[2] = 5'(a0); ra[3] = 5'(a1);
    step();
  endtask

  task automatic rnd_in();
    we = 2'($urandom);
    wa[0] = 5'($urandom_range(0, 31));
    wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 31));
    wd[0] = $urandom; wd[1] = $urandom;
    for (int i = 0; i < 4; i++)
      ra[i] = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
  endtask

  initial begin
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 34; n++) begin rnd_in(); step(); end
    drv(2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    drv(2'b00, 5, 0, 0, 0, 5, 6);
    drv(2'b11, 7, 32'h11, 7, 32'h22, 7, 8);
    drv(2'b00, 7, 0, 8, 0, 7, 8);
    drv(2'b11, 7, 32'h33, 8, 32'h44, 7, 8);
    drv(2'b00, 7, 0, 8, 0, 7, 8);
    drv(2'b01, 0, 32'h55, 0, 0, 0, 7);
    drv(2'b00, 0, 0, 0, 0, 0, 8);
    drv(2'b01, 6, 32'h66, 0, 0, 6, 30);
    drv(2'b01, 30, 32'hAB, 0, 0, 30, 6);
    drv(2'b00, 30, 0, 6, 0, 30, 6);
    for (int a = 0; a < 32; a++) drv(2'b01, a, 32'hFFFFFFFF, 0, 0, a, 0);
    rst = 1'b1; drv(2'b00, 0, 0, 0, 0, 3, 31);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin rnd_in(); step(); end
    rst = 1'b1; rnd_in(); step();
    rst = 1'b0;
    for (int n = 0; n < 34; n++) begin rnd_in(); step(); end
    for (int a = 0; a < 32; a += 4) begin
      we = '0;
      for (int i = 0; i < 4; i++) ra[i] = 5'(a + i);
      step();
    end
    for (int n = 0; n < 10000; n++) begin
      rnd_in();
      rst = ($urandom_range(0, 1999) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the two-read/one-write MIPS register file. It adds configurable width, depth and read-port count, a second write port with fixed priority, and optional write-to-read bypass so pipelined cores no longer need a falling-edge write. A post-reset clear sequencer zeroes every entry before the block reports ready. It sits in the decode stage of the single-cycle and pipelined datapaths.

## Interface
- WIDTH, 32: data width in bits
- DEPTH, 32: number of entries, ≥2 (need not be a power of two)
- NREAD, 2: number of combinational read ports, 1..8
- ZERO_REG, 1: 1 = entry 0 reads 0 and ignores writes
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads
- AW (localparam): $clog2(DEPTH)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- we  in  2  write enables; bit 1 is priority port
- wa  in  2×AW  write addresses, [1] and [0]
- wd  in  2×WIDTH  write data, [1] and [0]
- ra  in  NREAD×AW  read addresses
- rd  out  NREAD×WIDTH  read data, combinational
- ready  out  1  high once the clear sequence completes
- wcoll  out  1  registered one-cycle pulse: both ports wrote the same valid address

## Operation
- States: CLEAR, READY. RST=1 at an edge: state←CLEAR, clr_ptr←0, wcoll←0. Reset values: ready=0, wcoll=0.
- CLEAR, RST=0: each edge writes rf[clr_ptr]←0 and increments clr_ptr. On the edge where clr_ptr=DEPTH-1, state←READY.
- Reset asserted mid-clear restarts the sequence at clr_ptr=0.
- CLEAR: we is ignored, all rd=0, wcoll stays 0.
- READY, write: port p commits wd[p] to rf[wa[p]] when we[p]=1, wa[p]<DEPTH, and not (ZERO_REG and wa[p]=0).
- If both ports commit to the same address, port 1's data is stored. wcoll←1 on that edge, otherwise wcoll←0.
- Read port i:
  - rd[i]=0 if ra[i]≥DEPTH, or if ZERO_REG and ra[i]=0.
  - Otherwise, with BYPASS=1 and a committing write to ra[i] this cycle, rd[i] is that write's data, port 1 before port 0.
  - Otherwise rd[i]=rf[ra[i]].
- Out-of-range or zero-register writes are silently dropped. They never alias onto other entries.

## Timing
- Read latency is zero, combinational from ra, rf, and with BYPASS also from we, wa, wd.
- Write latency is one edge. Without bypass, data is visible on rd the cycle after the edge.
- ready rises exactly DEPTH rising edges after the first edge with RST=0. It stays high until the next RST.
- wcoll is valid the cycle after the colliding write and lasts one cycle.
- The only RST-dependent output path is through the state register. There is no asynchronous behaviour.

## Structure
- regfile_pkg holds:
  - the state enum (CLEAR, READY);
  - an address-width function, clog2 with a minimum of 1;
  - default WIDTH and DEPTH constants shared with the datapath packages.
- Sub-module regfile_clear_seq contains the state register, clr_ptr counter and ready output. It drives a clear-write enable and address into the storage array.
- Storage, write arbitration, bypass muxes and wcoll stay in regfile_mp. Read ports are generated with a for-generate loop.

## Test plan
- Reset with DEPTH=32: pulse RST for 1 cycle. ready=0 for 32 edges, then 1. All rd=0 throughout, including after preloading rf with 0xFFFFFFFF before reset.
- Write then read: READY, we=01, wa[0]=5, wd[0]=0xDEADBEEF.
  - BYPASS=1: rd[0] with ra[0]=5 shows 0xDEADBEEF in the same cycle.
  - BYPASS=0: rd[0] shows the old value until after the edge.
- Collision: we=11, wa[0]=wa[1]=7, wd[0]=0x11, wd[1]=0x22. rf[7]=0x22 and wcoll=1 for one cycle. Repeat with wa[1]=8: wcoll=0 and both entries written.
- Zero/range: with ZERO_REG=1, a write of 0x55 to address 0 leaves rd=0. With DEPTH=24, a write to address 30 is dropped, reading address 30 returns 0, and rf[6] is unchanged.
- Mid-clear reset: assert RST when clr_ptr=10. ready rises 32 edges after release. Writes issued during CLEAR have no effect.
- NREAD=4 random regression against a reference model for 10k cycles with random we/wa/wd/ra. All rd match every cycle.
